// File: rtl/sparc_ifu_thrsched_pkg.sv
// rtl/sparc_ifu_thrsched_pkg.sv - shared thread-state encodings and helpers for the IFU thread scheduler
package sparc_ifu_thrsched_pkg;

    localparam int NTHR = 4;

    localparam logic [1:0] ST_DEAD = 2'd0;
    localparam logic [1:0] ST_RDY  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    function automatic logic [1:0] onehot_to_idx(input logic [NTHR-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NTHR; i++) begin
            if (oh[i]) idx = idx | 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sparc_ifu_rrpick.sv
// rtl/sparc_ifu_rrpick.sv - combinational 4-way round-robin picker starting after the pointer
module sparc_ifu_rrpick
    import sparc_ifu_thrsched_pkg::*;
(
    input  logic [NTHR-1:0] elig,
    input  logic [1:0]      ptr,
    output logic [NTHR-1:0] grant,
    output logic            valid
);

    logic [1:0] idx;

    // Scan from farthest to nearest so the nearest eligible thread after ptr overwrites the rest.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = NTHR; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (elig[idx]) grant = NTHR'(1) << idx;
        end
        valid = |elig;
    end

endmodule

// File: rtl/sparc_ifu_thrsched.sv
// rtl/sparc_ifu_thrsched.sv - per-thread run-state tracker and fetch-thread scheduler for the 4-thread IFU
module sparc_ifu_thrsched
    import sparc_ifu_thrsched_pkg::*;
#(
    parameter int MAXRUN = 8,
    parameter int CNTW   = 4
) (
    input  logic            clk,
    input  logic            arst_l,
    input  logic            se,
    input  logic [NTHR-1:0] thr_active,
    input  logic [NTHR-1:0] thr_start,
    input  logic [NTHR-1:0] thr_halt,
    input  logic [NTHR-1:0] wait_set,
    input  logic [NTHR-1:0] completion,
    input  logic            stall_s,
    output logic [NTHR-1:0] thr_s1,
    output logic            thr_vld_s1,
    output logic [NTHR-1:0] thr_rdy,
    output logic [NTHR-1:0] thr_wait,
    output logic            force_sw
);

    logic [NTHR-1:0][1:0] st, ev_ns, st_nxt;
    logic [NTHR-1:0]      elig, pick_grant, sel_nxt;
    logic [1:0]           ptr, ptr_nxt;
    logic [CNTW-1:0]      run_cnt, cnt_nxt;
    logic                 pick_vld, cur_elig, others, at_limit, force_nxt;
    logic                 unused_se;

    assign unused_se = se;

    // Inactive threads ignore events; only a held RUN gets demoted below.
    always_comb begin
        for (int i = 0; i < NTHR; i++) begin
            ev_ns[i] = st[i];
            if (thr_active[i]) begin
                if (thr_halt[i])                             ev_ns[i] = ST_DEAD;
                else if (wait_set[i] && st[i] != ST_DEAD)    ev_ns[i] = ST_WAIT;
                else if (completion[i] && st[i] == ST_WAIT)  ev_ns[i] = ST_RDY;
                else if (thr_start[i] && st[i] == ST_DEAD)   ev_ns[i] = ST_RDY;
            end
            elig[i] = thr_active[i] && (ev_ns[i] == ST_RDY || ev_ns[i] == ST_RUN);
        end
    end

    sparc_ifu_rrpick u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .grant (pick_grant),
        .valid (pick_vld)
    );

    assign cur_elig = |(thr_s1 & elig);
    assign others   = |(elig & ~thr_s1);
    assign at_limit = (run_cnt >= CNTW'(MAXRUN - 1));

    always_comb begin
        sel_nxt   = '0;
        cnt_nxt   = '0;
        ptr_nxt   = ptr;
        force_nxt = 1'b0;
        if (stall_s) begin
            if (cur_elig) begin
                sel_nxt = thr_s1;
                cnt_nxt = run_cnt;
            end
        end else if (cur_elig && (!at_limit || !others)) begin
            sel_nxt = thr_s1;
            cnt_nxt = at_limit ? run_cnt : run_cnt + 1'b1;
        end else if (pick_vld) begin
            sel_nxt   = pick_grant;
            ptr_nxt   = onehot_to_idx(pick_grant);
            force_nxt = cur_elig;
        end
    end

    always_comb begin
        for (int i = 0; i < NTHR; i++) begin
            if (sel_nxt[i])               st_nxt[i] = ST_RUN;
            else if (ev_ns[i] == ST_RUN)  st_nxt[i] = ST_RDY;
            else                          st_nxt[i] = ev_ns[i];
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            st       <= '0;
            thr_s1   <= '0;
            ptr      <= 2'd3;
            run_cnt  <= '0;
            force_sw <= 1'b0;
        end else begin
            st       <= st_nxt;
            thr_s1   <= sel_nxt;
            ptr      <= ptr_nxt;
            run_cnt  <= cnt_nxt;
            force_sw <= force_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < NTHR; i++) begin
            thr_rdy[i]  = (st[i] == ST_RDY) || (st[i] == ST_RUN);
            thr_wait[i] = (st[i] == ST_WAIT);
        end
    end

    assign thr_vld_s1 = |thr_s1;

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// tb/tb_sparc_ifu_thrsched.sv - self-checking bench for the IFU thread scheduler
module tb_sparc_ifu_thrsched;

    localparam int MAXRUN = 8;

    logic       clk = 1'b0;
    logic       arst_l, se, stall_s;
    logic [3:0] thr_active, thr_start, thr_halt, wait_set, completion;
    logic [3:0] thr_s1, thr_rdy, thr_wait;
    logic       thr_vld_s1, force_sw;

    always #5 clk = ~clk;

    sparc_ifu_thrsched #(.MAXRUN(MAXRUN), .CNTW(4)) dut (
        .clk        (clk),
        .arst_l     (arst_l),
        .se         (se),
        .thr_active (thr_active),
        .thr_start  (thr_start),
        .thr_halt   (thr_halt),
        .wait_set   (wait_set),
        .completion (completion),
        .stall_s    (stall_s),
        .thr_s1     (thr_s1),
        .thr_vld_s1 (thr_vld_s1),
        .thr_rdy    (thr_rdy),
        .thr_wait   (thr_wait),
        .force_sw   (force_sw)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: 0=DEAD 1=RDY 2=RUN 3=WAIT; m_run is the fetching thread or -1.
    int m_st[4];
    int m_run, m_cnt, m_ptr;
    bit m_force;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_sel();
        return (m_run >= 0) ? 4'(1 << m_run) : 4'b0000;
    endfunction

    function automatic logic [3:0] m_mask(input int a, input int b);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (m_st[i] == a) || (m_st[i] == b);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_st[i] = 0;
        m_run   = -1;
        m_cnt   = 0;
        m_ptr   = 3;
        m_force = 1'b0;
    endtask

    task automatic model_step();
        int ns[4];
        bit el[4];
        int n_el;
        int pick;
        bit keep;
        n_el = 0;
        pick = -1;
        for (int i = 0; i < 4; i++) begin
            ns[i] = m_st[i];
            if (thr_active[i]) begin
                if (thr_halt[i])                        ns[i] = 0;
                else if (wait_set[i] && m_st[i] != 0)   ns[i] = 3;
                else if (completion[i] && m_st[i] == 3) ns[i] = 1;
                else if (thr_start[i] && m_st[i] == 0)  ns[i] = 1;
            end
            el[i] = thr_active[i] && (ns[i] == 1 || ns[i] == 2);
            if (el[i]) n_el++;
        end
        m_force = 1'b0;
        if (stall_s) begin
            if (m_run >= 0 && !el[m_run]) m_run = -1;
            if (m_run < 0) m_cnt = 0;
        end else begin
            keep = (m_run >= 0) && el[m_run] && (m_cnt < MAXRUN - 1 || n_el == 1);
            if (keep) begin
                if (m_cnt < MAXRUN - 1) m_cnt++;
            end else begin
                for (int k = 1; k <= 4; k++)
                    if (pick < 0 && el[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
                if (pick >= 0) begin
                    m_force = (m_run >= 0) && el[m_run];
                    m_run   = pick;
                    m_ptr   = pick;
                end else begin
                    m_run = -1;
                end
                m_cnt = 0;
            end
        end
        for (int i = 0; i < 4; i++)
            m_st[i] = (i == m_run) ? 2 : ((ns[i] == 2) ? 1 : ns[i]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sel", thr_s1, m_sel());
            chk("vld", thr_vld_s1, (m_run >= 0));
            chk("rdy", thr_rdy, m_mask(1, 2));
            chk("wait", thr_wait, m_mask(3, 3));
            chk("force", force_sw, m_force);
        end
    end

    task automatic cyc(input logic [3:0] s, input logic [3:0] h, input logic [3:0] w,
                       input logic [3:0] c, input logic stl);
        thr_start  = s;
        thr_halt   = h;
        wait_set   = w;
        completion = c;
        stall_s    = stl;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic async_reset();
        arst_l = 1'b0;
        #1;
        chk("arst_sel", thr_s1, 4'b0000);
        chk("arst_vld", thr_vld_s1, 1'b0);
        chk("arst_rdy", thr_rdy, 4'b0000);
        chk("arst_wait", thr_wait, 4'b0000);
        chk("arst_force", force_sw, 1'b0);
        model_reset();
        #1;
        arst_l = 1'b1;
    endtask

    initial begin
        int n;
        arst_l = 1'b0; se = 1'b0; stall_s = 1'b0;
        thr_active = 4'hF; thr_start = '0; thr_halt = '0; wait_set = '0; completion = '0;
        model_reset();
        #12;
        chk("rst_sel", thr_s1, 4'b0000);
        chk("rst_vld", thr_vld_s1, 1'b0);
        chk("rst_rdy", thr_rdy, 4'b0000);
        chk("rst_force", force_sw, 1'b0);
        #10;
        arst_l = 1'b1;
        chk_en = 1'b1;

        cyc(4'b0101, 0, 0, 0, 0);
        chk("start_rdy", thr_rdy, 4'b0101);
        chk("start_sel", thr_s1, 4'b0001);
        chk("start_vld", thr_vld_s1, 1'b1);

        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk("limit_hold_t0", thr_s1, 4'b0001);
        end
        cyc(0, 0, 0, 0, 0);
        chk("limit_sw_t2", thr_s1, 4'b0100);
        chk("limit_force", force_sw, 1'b1);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk("limit_hold_t2", thr_s1, 4'b0100);
            chk("limit_force_low", force_sw, 1'b0);
        end
        cyc(0, 0, 0, 0, 0);
        chk("limit_back_t0", thr_s1, 4'b0001);

        cyc(0, 0, 4'b0001, 0, 0);
        chk("wait_sel", thr_s1, 4'b0100);
        chk("wait_mask", thr_wait, 4'b0001);
        chk("wait_force", force_sw, 1'b0);
        cyc(0, 0, 0, 4'b0001, 0);
        chk("wake_rdy", thr_rdy, 4'b0101);
        chk("wake_wait", thr_wait, 4'b0000);

        cyc(0, 0, 4'b0100, 4'b0100, 0);
        chk("coll_wait", thr_wait, 4'b0100);
        chk("coll_sel", thr_s1, 4'b0001);
        cyc(0, 4'b0001, 4'b0001, 0, 0);
        chk("halt_rdy", thr_rdy, 4'b0000);
        chk("halt_vld", thr_vld_s1, 1'b0);

        cyc(0, 4'b1111, 0, 0, 0);
        cyc(4'b0011, 0, 0, 0, 0);
        chk("restart_sel", thr_s1, 4'b0010);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0);
        chk("pre_stall_sel", thr_s1, 4'b0001);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk("stall_sel", thr_s1, 4'b0001);
            chk("stall_force", force_sw, 1'b0);
        end
        n = 0;
        do begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end while (thr_s1 == 4'b0001 && n < 20);
        chk("stall_release_len", n, 8);
        chk("stall_release_sel", thr_s1, 4'b0010);
        n = 0;
        while (thr_s1 != 4'b0001 && n < 20) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        chk("t0_running", thr_s1, 4'b0001);
        cyc(0, 0, 4'b0001, 0, 1);
        chk("stall_wait_sel", thr_s1, 4'b0000);
        chk("stall_wait_vld", thr_vld_s1, 1'b0);
        cyc(0, 0, 0, 0, 1);
        chk("stall_idle_sel", thr_s1, 4'b0000);
        cyc(0, 0, 0, 0, 0);
        chk("unstall_sel", thr_s1, 4'b0010);

        async_reset();
        cyc(4'b1111, 0, 0, 0, 0);
        chk("post_rst_sel", thr_s1, 4'b0001);

        for (int c = 0; c < 3000; c++) begin
            logic [3:0] s, h, w, p;
            for (int i = 0; i < 4; i++) begin
                thr_active[i] = ($urandom_range(0, 7) != 0);
                s[i] = ($urandom_range(0, 3) == 0);
                h[i] = ($urandom_range(0, 31) == 0);
                w[i] = ($urandom_range(0, 7) == 0);
                p[i] = ($urandom_range(0, 5) == 0);
            end
            se = 1'($urandom_range(0, 1));
            cyc(s, h, w, p, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
